// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared constants and helpers for the frequency meter and
//                the clock-divider top levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

   // Board clock frequency in Hz
   localparam int CLK_HZ = 100_000_000;

   // One-second gate window at the board clock rate
   localparam int DEFAULT_GATE_CYCLES = CLK_HZ;

   // Period-measurement states
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } period_state_t;

   // Bits needed to hold the values 0..n-1 (never less than one bit)
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((longint'(1) << w) < longint'(n)) begin
         w++;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_rise_detect
//  Description : Multi-flop synchronizer for an asynchronous input followed
//                by a history flop; emits a one-cycle pulse per rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_rise_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   history;

   // Shift the input through the synchronizer, then keep one cycle of history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff <= '0;
         history <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
         history <= sync_ff[SYNC_STAGES-1];
      end
   end

   assign rise = sync_ff[SYNC_STAGES-1] & ~history;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Measures a slow external signal: rising edges per gate
//                window (saturating, with overflow flag) and the period of
//                the last cycle in clk cycles (with no-edge timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
   parameter int COUNT_W     = 16,
   parameter int PERIOD_W    = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sig_in,
   output logic [COUNT_W-1:0]  freq_count,
   output logic                freq_valid,
   output logic                freq_ovf,
   output logic [PERIOD_W-1:0] period_out,
   output logic                period_valid,
   output logic                period_timeout
);

   localparam int                  GATE_W     = cnt_width(GATE_CYCLES);
   localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
   localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;
   // Last pcnt value before the period counter would run out of range
   localparam logic [PERIOD_W-1:0] PCNT_LIMIT = {{(PERIOD_W-1){1'b1}}, 1'b0};

   logic                rise;
   logic                gate_tc;
   logic                edge_at_max;
   logic [GATE_W-1:0]   gate_cnt;
   logic [COUNT_W-1:0]  edge_cnt;
   logic                edge_ovf;
   period_state_t       state;
   logic [PERIOD_W-1:0] pcnt;

   sync_rise_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_rise (
      .clk      (clk),
      .rst      (rst),
      .async_in (sig_in),
      .rise     (rise)
   );

   assign gate_tc     = (gate_cnt == GATE_LAST);
   assign edge_at_max = (edge_cnt == COUNT_MAX);

   // Free-running gate counter defining back-to-back measurement windows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
      end else if (gate_tc) begin
         gate_cnt <= '0;
      end else begin
         gate_cnt <= gate_cnt + 1'b1;
      end
   end

   // Edge counting; a rise in the terminal cycle is folded into the closing window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt   <= '0;
         edge_ovf   <= 1'b0;
         freq_count <= '0;
         freq_ovf   <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= gate_tc;
         if (gate_tc) begin
            freq_count <= (rise && !edge_at_max) ? edge_cnt + 1'b1 : edge_cnt;
            freq_ovf   <= edge_ovf | (rise & edge_at_max);
            edge_cnt   <= '0;
            edge_ovf   <= 1'b0;
         end else if (rise) begin
            if (edge_at_max) begin
               edge_ovf <= 1'b1;
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

   // Period FSM: first rise arms the counter, each later rise reports a period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         pcnt           <= '0;
         period_out     <= '0;
         period_valid   <= 1'b0;
         period_timeout <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  pcnt           <= '0;
                  period_timeout <= 1'b0;
                  state          <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (rise) begin
                  period_out   <= pcnt + 1'b1;
                  period_valid <= 1'b1;
                  pcnt         <= '0;
               end else if (pcnt == PCNT_LIMIT) begin
                  period_timeout <= 1'b1;
                  state          <= ST_IDLE;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Self-checking bench for freq_meter. Two instances: a wide
//                one (1000-cycle gate) and a narrow one (4-bit count, 8-bit
//                period, 100-cycle gate) for saturation, timeout and
//                window-boundary cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

   localparam int GA     = 1000;
   localparam int GB     = 100;
   localparam int CWA    = 16;
   localparam int PWA    = 24;
   localparam int CWB    = 4;
   localparam int PWB    = 8;
   localparam int SYNC   = 2;
   localparam int LAT    = SYNC + 1;        // drive cycle -> cycle the rise is consumed
   localparam int A_CMAX = (1 << CWA) - 1;
   localparam int A_PMAX = (1 << PWA) - 1;
   localparam int B_CMAX = (1 << CWB) - 1;
   localparam int B_PMAX = (1 << PWB) - 1;

   typedef struct {int cnt; int ovf;} fexp_t;
   typedef struct {int per; int at;} pexp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic sig_a = 1'b0;
   logic sig_b = 1'b0;

   logic [CWA-1:0] a_fcount;
   logic           a_fvalid, a_fovf;
   logic [PWA-1:0] a_pout;
   logic           a_pvalid, a_ptmo;
   logic [CWB-1:0] b_fcount;
   logic           b_fvalid, b_fovf;
   logic [PWB-1:0] b_pout;
   logic           b_pvalid, b_ptmo;

   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;
   fexp_t a_fq[$], b_fq[$];
   pexp_t a_pq[$], b_pq[$];
   int    a_win[int], b_win[int];
   int    a_last = -1, b_last = -1;
   int    b_last_per = 0;
   fexp_t m_fe;
   pexp_t m_pe;
   int    m_w, m_n;

   freq_meter #(.GATE_CYCLES(GA), .COUNT_W(CWA), .PERIOD_W(PWA), .SYNC_STAGES(SYNC)) u_a (
      .clk(clk), .rst(rst), .sig_in(sig_a),
      .freq_count(a_fcount), .freq_valid(a_fvalid), .freq_ovf(a_fovf),
      .period_out(a_pout), .period_valid(a_pvalid), .period_timeout(a_ptmo));

   freq_meter #(.GATE_CYCLES(GB), .COUNT_W(CWB), .PERIOD_W(PWB), .SYNC_STAGES(SYNC)) u_b (
      .clk(clk), .rst(rst), .sig_in(sig_b),
      .freq_count(b_fcount), .freq_valid(b_fvalid), .freq_ovf(b_fovf),
      .period_out(b_pout), .period_valid(b_pvalid), .period_timeout(b_ptmo));

   always #5 clk = ~clk;

   // Clock edges since reset release
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Record a rising edge driven now: its window and the period it will report
   task automatic note_rise(input bit on_b);
      int c, w;
      pexp_t p;
      c = cyc + LAT;
      if (!on_b) begin
         w = (c - 1) / GA;
         a_win[w] = a_win.exists(w) ? a_win[w] + 1 : 1;
         if (a_last >= 0 && c - a_last <= A_PMAX) begin
            p.per = c - a_last; p.at = c; a_pq.push_back(p);
         end
         a_last = c;
      end else begin
         w = (c - 1) / GB;
         b_win[w] = b_win.exists(w) ? b_win[w] + 1 : 1;
         if (b_last >= 0 && c - b_last <= B_PMAX) begin
            p.per = c - b_last; p.at = c; b_pq.push_back(p);
            b_last_per = p.per;
         end
         b_last = c;
      end
   endtask

   task automatic set_sig(input bit on_b, input logic v);
      if (on_b) sig_b = v;
      else      sig_a = v;
   endtask

   task automatic drive_square(input bit on_b, input int period, input int ncyc);
      for (int i = 0; i < ncyc; i += period) begin
         @(negedge clk);
         set_sig(on_b, 1'b1);
         note_rise(on_b);
         repeat (period / 2) @(negedge clk);
         set_sig(on_b, 1'b0);
         repeat (period - period / 2 - 1) @(negedge clk);
      end
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < target) check("wait_bound", cyc, target);
   endtask

   // Scoreboard: push expected window results at each boundary, pop on output
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if ((cyc > 0 && cyc % GA == 0) || a_fvalid) begin
            check("a_fvalid", a_fvalid, (cyc > 0 && cyc % GA == 0));
            if (cyc > 0 && cyc % GA == 0) begin
               m_w = cyc / GA - 1;
               m_n = a_win.exists(m_w) ? a_win[m_w] : 0;
               m_fe.cnt = (m_n > A_CMAX) ? A_CMAX : m_n;
               m_fe.ovf = (m_n > A_CMAX) ? 1 : 0;
               a_fq.push_back(m_fe);
               if (a_fvalid) begin
                  m_fe = a_fq.pop_front();
                  check("a_fcount", a_fcount, m_fe.cnt);
                  check("a_fovf", a_fovf, m_fe.ovf);
               end
            end
         end
         if ((cyc > 0 && cyc % GB == 0) || b_fvalid) begin
            check("b_fvalid", b_fvalid, (cyc > 0 && cyc % GB == 0));
            if (cyc > 0 && cyc % GB == 0) begin
               m_w = cyc / GB - 1;
               m_n = b_win.exists(m_w) ? b_win[m_w] : 0;
               m_fe.cnt = (m_n > B_CMAX) ? B_CMAX : m_n;
               m_fe.ovf = (m_n > B_CMAX) ? 1 : 0;
               b_fq.push_back(m_fe);
               if (b_fvalid) begin
                  m_fe = b_fq.pop_front();
                  check("b_fcount", b_fcount, m_fe.cnt);
                  check("b_fovf", b_fovf, m_fe.ovf);
               end
            end
         end
         if (a_pvalid) begin
            if (a_pq.size() == 0) check("a_pvalid_unexpected", a_pvalid, 0);
            else begin
               m_pe = a_pq.pop_front();
               check("a_period", a_pout, m_pe.per);
               check("a_period_cyc", cyc, m_pe.at);
            end
         end
         if (b_pvalid) begin
            if (b_pq.size() == 0) check("b_pvalid_unexpected", b_pvalid, 0);
            else begin
               m_pe = b_pq.pop_front();
               check("b_period", b_pout, m_pe.per);
               check("b_period_cyc", cyc, m_pe.at);
            end
         end
      end
   end

   initial begin
      int k, d, t0, n;

      // Reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_a_fcount", a_fcount, 0);  check("rst_a_fvalid", a_fvalid, 0);
      check("rst_a_fovf", a_fovf, 0);      check("rst_a_pout", a_pout, 0);
      check("rst_a_pvalid", a_pvalid, 0);  check("rst_a_ptmo", a_ptmo, 0);
      check("rst_b_fcount", b_fcount, 0);  check("rst_b_fvalid", b_fvalid, 0);
      check("rst_b_fovf", b_fovf, 0);      check("rst_b_pout", b_pout, 0);
      check("rst_b_pvalid", b_pvalid, 0);  check("rst_b_ptmo", b_ptmo, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Period-10 square wave on the wide instance
      drive_square(1'b0, 10, 2600);

      // Saturation at period 4, then recovery at period 20
      drive_square(1'b1, 4, 300);
      drive_square(1'b1, 20, 300);
      repeat (300) @(negedge clk);

      // Lone rise then silence: timeout after 255 cycles, period held
      @(negedge clk);
      sig_b = 1'b1; note_rise(1'b1); t0 = cyc + LAT;
      repeat (5) @(negedge clk);
      sig_b = 1'b0;
      wait_until(t0 + 250);
      check("b_ptmo_early", b_ptmo, 0);
      wait_until(t0 + 256);
      check("b_ptmo_set", b_ptmo, 1);
      check("b_pout_hold", b_pout, b_last_per);

      // Two rises 30 cycles apart: timeout clears on the first, period on the second
      repeat (20) @(negedge clk);
      d = cyc;
      sig_b = 1'b1; note_rise(1'b1);
      wait_until(d + LAT - 1);
      check("b_ptmo_before_rise", b_ptmo, 1);
      wait_until(d + LAT);
      check("b_ptmo_cleared", b_ptmo, 0);
      wait_until(d + 5);
      sig_b = 1'b0;
      wait_until(d + 30);
      sig_b = 1'b1; note_rise(1'b1);
      wait_until(d + 30 + LAT);
      check("b_pout_30", b_pout, 30);
      check("b_pvalid_30", b_pvalid, 1);
      wait_until(d + 35);
      sig_b = 1'b0;

      // Rise consumed exactly in the gate terminal cycle
      k = (cyc + 10) / GB + 2;
      wait_until(k * GB - LAT);
      sig_b = 1'b1; note_rise(1'b1);
      wait_until(k * GB);
      check("b_tc_valid", b_fvalid, 1);
      check("b_tc_count", b_fcount, 1);
      sig_b = 1'b0;
      wait_until((k + 1) * GB);
      check("b_new_window", b_fcount, 0);

      // One-clock pulse at a random phase within the cycle
      @(posedge clk);
      #($urandom_range(1, 9));
      sig_b = 1'b1; note_rise(1'b1);
      #10 sig_b = 1'b0;
      wait_until((k + 2) * GB);
      check("b_pulse_count", b_fcount, 1);

      // Asynchronous reset mid-window and mid-period
      drive_square(1'b1, 20, 150);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_b_fcount", b_fcount, 0);  check("arst_b_fvalid", b_fvalid, 0);
      check("arst_b_fovf", b_fovf, 0);      check("arst_b_pout", b_pout, 0);
      check("arst_b_pvalid", b_pvalid, 0);  check("arst_b_ptmo", b_ptmo, 0);
      check("arst_a_fcount", a_fcount, 0);  check("arst_a_pout", a_pout, 0);
      check("pre_rst_b_pq", b_pq.size(), 0);
      check("pre_rst_a_pq", a_pq.size(), 0);
      check("pre_rst_b_fq", b_fq.size(), 0);
      check("pre_rst_a_fq", a_fq.size(), 0);
      a_win.delete(); b_win.delete();
      a_pq.delete(); b_pq.delete(); a_fq.delete(); b_fq.delete();
      a_last = -1; b_last = -1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #4;
      rst = 1'b0;
      mon_en = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_fvalid && n < 3 * GB) begin
         @(negedge clk);
         n++;
      end
      check("b_first_valid_cyc", cyc, GB);
      wait_until(GA + 2);

      check("end_a_pq", a_pq.size(), 0);
      check("end_b_pq", b_pq.size(), 0);
      check("end_a_fq", a_fq.size(), 0);
      check("end_b_fq", b_fq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
